// File: rtl/lbp_code_rx.sv
// lbp_code_rx: synchronizes the comparator line, assembles LBP codes and queues them in a FIFO
// Optional build macro LBP_RX_MAJORITY_EN: capture bit is majority(s2,s3,s4) to reject one-cycle chatter.
module lbp_code_rx #(
   parameter int NBITS = 12,
   parameter int DEPTH = 4
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       cmp_i,
   input  logic                       start_i,
   input  logic                       sample_i,
   output logic [NBITS-1:0]           code_o,
   output logic                       code_valid_o,
   input  logic                       code_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
   output logic                       busy_o,
   output logic                       overflow_o,
   input  logic                       ovf_clr_i
);
   localparam int CW = $clog2(NBITS);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] LAST = CW'(NBITS-1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [NBITS-1:0] sh_q;
   logic             busy_q;
   logic             s1_q, s2_q, cap;
   logic [NBITS-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, rp_q;
   logic [LW-1:0]    lvl_q;
   logic             ovf_q;
   logic             push, pop, wr, drop;

`ifdef LBP_RX_MAJORITY_EN
   logic s3_q, s4_q;

   // four-flop chain; the two extra stages feed the majority vote
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) {s1_q, s2_q, s3_q, s4_q} <= '0;
      else {s1_q, s2_q, s3_q, s4_q} <= {cmp_i, s1_q, s2_q, s3_q};
   end

   assign cap = (s2_q & s3_q) | (s2_q & s4_q) | (s3_q & s4_q);
`else
   // two-flop synchronizer for the asynchronous comparator line
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) {s1_q, s2_q} <= '0;
      else {s1_q, s2_q} <= {cmp_i, s1_q};
   end

   assign cap = s2_q;
`endif

   // sequencer FSM: start clears and (re)starts a code, each sample shifts in one bit, PUSH hands it to the FIFO
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         busy_q  <= 1'b0;
      end else if (start_i) begin
         state_q <= SHIFT;
         cnt_q   <= '0;
         sh_q    <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == SHIFT && sample_i) begin
         sh_q[cnt_q] <= cap;
         cnt_q       <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
         state_q     <= (cnt_q == LAST) ? PUSH : SHIFT;
      end else if (state_q == PUSH) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end
   end

   assign push = (state_q == PUSH);
   assign pop  = code_valid_o && code_ready_i;
   assign wr   = push && (lvl_q != FULL || pop);
   assign drop = push && !wr;

   // FIFO storage; contents need no reset because the output is gated by valid
   always_ff @(posedge wb_clk_i) begin
      if (wr) mem_q[wp_q] <= sh_q;
   end

   // FIFO pointers, level and sticky overflow (a drop outranks a clear)
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wr ? wp_q + 1'b1 : wp_q;
         rp_q  <= pop ? rp_q + 1'b1 : rp_q;
         lvl_q <= (wr && !pop) ? lvl_q + 1'b1 : (pop && !wr) ? lvl_q - 1'b1 : lvl_q;
         ovf_q <= drop ? 1'b1 : ovf_clr_i ? 1'b0 : ovf_q;
      end
   end

   assign code_valid_o = (lvl_q != '0);
   assign code_o       = code_valid_o ? mem_q[rp_q] : '0;
   assign fifo_level_o = lvl_q;
   assign busy_o       = busy_q;
   assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_lbp_code_rx.sv
// tb_lbp_code_rx: directed self-checking bench for lbp_code_rx
module tb_lbp_code_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmp = 1'b0, start = 1'b0, sample = 1'b0, ready = 1'b0, ovf_clr = 1'b0;
   logic [11:0] code;
   logic        valid, busy, ovf;
   logic [2:0]  level;
   int          n_vec = 0, n_err = 0;
   logic [11:0] exp_q [$];

   lbp_code_rx #(.NBITS(12), .DEPTH(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cmp_i(cmp), .start_i(start), .sample_i(sample),
      .code_o(code), .code_valid_o(valid), .code_ready_i(ready), .fifo_level_o(level),
      .busy_o(busy), .overflow_o(ovf), .ovf_clr_i(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bits(input logic [11:0] c, input int n);
      for (int i = 0; i < n; i++) begin
         cmp = c[i];
         repeat (3) @(negedge clk);
         sample = 1'b1;
         @(negedge clk);
         sample = 1'b0;
      end
   endtask

   task automatic send_code(input logic [11:0] c);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_bits(c, 12);
   endtask

   task automatic drain(input string tag);
      ready = 1'b1;
      while (exp_q.size() > 0) begin
         check({tag, "_head"}, code, exp_q.pop_front());
         @(negedge clk);
      end
      ready = 1'b0;
      check({tag, "_empty"}, valid, 0);
   endtask

   initial begin
      logic [11:0] glitch_exp;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_code", code, 0);
      check("rst_valid", valid, 0);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);

      send_code(12'h90D);
      check("push_busy", busy, 1);
      check("push_valid", valid, 0);
      @(negedge clk);
      check("first_code", code, 12'h90D);
      check("first_valid", valid, 1);
      check("first_level", level, 1);
      check("first_busy", busy, 0);
      exp_q.push_back(12'h90D);
      drain("first");

      for (int k = 0; k < 5; k++) begin
         send_code(12'h101 * (k + 1));
         @(negedge clk);
         if (k < 4) exp_q.push_back(12'h101 * (k + 1));
      end
      check("ovf_level", level, 4);
      check("ovf_set", ovf, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_clr", ovf, 0);
      drain("ovf");

      for (int k = 0; k < 5; k++) begin
         send_code(12'h0F0 + 12'(k));
         if (k == 4) ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
         if (k > 0) exp_q.push_back(12'h0F0 + 12'(k));
      end
      check("coin_level", level, 4);
      check("coin_ovf", ovf, 0);
      drain("coin");

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_bits(12'h055, 7);
      send_code(12'hFFF);
      @(negedge clk);
      check("restart_level", level, 1);
      exp_q.push_back(12'hFFF);
      drain("restart");

      send_code(12'h123);
      @(negedge clk);
      send_code(12'h456);
      @(negedge clk);
      check("pre_rst_level", level, 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_bits(12'h01F, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_level", level, 0);
      check("midrst_valid", valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_code", code, 0);
      send_code(12'hA5C);
      @(negedge clk);
      check("postrst_level", level, 1);
      exp_q.push_back(12'hA5C);
      drain("postrst");

      cmp = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cmp = 1'b1;
      @(negedge clk);
      cmp = 1'b0;
      @(negedge clk);
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
      send_bits(12'h000, 11);
      @(negedge clk);
`ifdef LBP_RX_MAJORITY_EN
      glitch_exp = 12'h000;
`else
      glitch_exp = 12'h001;
`endif
      check("glitch_level", level, 1);
      exp_q.push_back(glitch_exp);
      drain("glitch");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
